// File: rtl/vcu118_reset_request_if.sv
// Purpose: bundles the reset-request sources and the reset/cause/running results.
// Latency: none, wiring only.
// Backpressure: none; all signals are levels or single-cycle pulses.
interface vcu118_reset_request_if;
    logic       button;
    logic       pll_locked;
    logic       sw_req;
    logic       wdog_en;
    logic       wdog_kick;
    logic       cause_clr;
    logic       areset;
    logic [4:0] cause;
    logic       running;

    // Source side: drives requests, observes the reset result
    modport master (
        output button, pll_locked, sw_req, wdog_en, wdog_kick, cause_clr,
        input  areset, cause, running
    );

    // Reset generator side
    modport slave (
        input  button, pll_locked, sw_req, wdog_en, wdog_kick, cause_clr,
        output areset, cause, running
    );
endinterface

// File: rtl/vcu118_reset_request.sv
// Purpose: merges POR/button/sw/watchdog/PLL-loss into one areset level with a sticky cause.
// Latency: request in RUN -> areset after 1 edge; release after HOLD_CYCLES + LOCK_CYCLES stable lock.
// Backpressure: none; every request is accepted, and a request during reset restarts the hold.
module vcu118_reset_request #(
    parameter int HOLD_CYCLES   = 1024,
    parameter int LOCK_CYCLES   = 256,
    parameter int DEBOUNCE_BITS = 8,
    parameter int WDOG_BITS     = 24
) (
    input  logic                  clock,
    input  logic                  resetn,
    vcu118_reset_request_if.slave rr
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int DW = DEBOUNCE_BITS + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(1) << DEBOUNCE_BITS;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [WDOG_BITS-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [DW-1:0]  deb_cnt_q, deb_cnt_d;
    logic           deb_arm_q, deb_arm_d;
    logic [4:0]     cause_q, cause_d;
    logic           areset_q;
    logic           running_q;

    logic           btn_meta_q, btn_s_q;
    logic           lock_meta_q, lock_s_q;

    logic           btn_req;
    logic           wdog_req;
    logic           pll_req;
    logic [4:1]     req;
    logic           req_any;

    // Two-flop synchronisers for the asynchronous inputs; deliberately unreset
    always_ff @(posedge clock) begin
        btn_meta_q  <= rr.button;
        btn_s_q     <= btn_meta_q;
        lock_meta_q <= rr.pll_locked;
        lock_s_q    <= lock_meta_q;
    end

    // Debounce: count stable cycles at the armed level; only the armed-high completion requests
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_arm_d = deb_arm_q;
        btn_req   = 1'b0;
        if (deb_cnt_q == DEB_MAX) begin
            btn_req   = deb_arm_q;
            deb_arm_d = ~deb_arm_q;
            deb_cnt_d = '0;
        end else if (btn_s_q == deb_arm_q) begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end else begin
            deb_cnt_d = '0;
        end
    end

    // Watchdog counts only while running, enabled and not kicked
    always_comb begin
        wdog_req = (&wdog_cnt_q) & ~rr.wdog_kick;
        if ((state_q != ST_RUN) || !rr.wdog_en || rr.wdog_kick) begin
            wdog_cnt_d = '0;
        end else begin
            wdog_cnt_d = wdog_cnt_q + WDOG_BITS'(1);
        end
    end

    // Lock loss only matters in RUN; WAIT_LOCK already tolerates an unlocked PLL
    assign pll_req = (state_q == ST_RUN) & ~lock_s_q;
    assign req     = {pll_req, wdog_req, rr.sw_req, btn_req};
    assign req_any = |req;

    // Sequencer next-state: any request (re)starts the hold, then wait for a stable lock
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (req_any) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_WAIT_LOCK;
                    lock_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (req_any) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else if (lock_s_q && (lock_cnt_q == LOCK_LAST)) begin
                    state_d = ST_RUN;
                end else if (lock_s_q) begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end else begin
                    lock_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (req_any) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Cause: a fresh reset from RUN replaces history, requests during reset accumulate
    always_comb begin
        cause_d = cause_q;
        if (state_q == ST_RUN) begin
            if (req_any) begin
                cause_d = {req, 1'b0};
            end else if (rr.cause_clr) begin
                cause_d = '0;
            end
        end else begin
            cause_d = cause_q | {req, 1'b0};
        end
    end

    // State and counters; outputs registered from next-state so they align with the state
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            lock_cnt_q <= '0;
            wdog_cnt_q <= '0;
            deb_cnt_q  <= '0;
            deb_arm_q  <= 1'b1;
            cause_q    <= 5'b00001;
            areset_q   <= 1'b1;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            wdog_cnt_q <= wdog_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            deb_arm_q  <= deb_arm_d;
            cause_q    <= cause_d;
            areset_q   <= (state_d != ST_RUN);
            running_q  <= (state_d == ST_RUN);
        end
    end

    assign rr.areset  = areset_q;
    assign rr.cause   = cause_q;
    assign rr.running = running_q;

endmodule

// File: tb/tb_vcu118_reset_request.sv
// Purpose: scoreboard bench for vcu118_reset_request with randomized scenario timing.
// Latency: expected areset edges are predicted from the timing rules and queued.
// Backpressure: none; the monitor pops one expectation per observed areset edge.
module tb_vcu118_reset_request;

    localparam int HOLD    = 16;
    localparam int LOCK    = 8;
    localparam int DEB     = 8;   // 2^DEBOUNCE_BITS
    localparam int SYNC    = 2;
    localparam int WDOG_TO = 64;  // 2^WDOG_BITS

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;

    vcu118_reset_request_if rr();

    vcu118_reset_request #(
        .HOLD_CYCLES  (HOLD),
        .LOCK_CYCLES  (LOCK),
        .DEBOUNCE_BITS(3),
        .WDOG_BITS    (6)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .rr    (rr)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic       lvl;
        int         at;
        logic [4:0] cause;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;
    logic prev_ar = 1'b1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every areset edge must match the oldest prediction
    always @(negedge clock) begin
        if (mon_en && (rr.areset !== prev_ar)) begin
            if (sbq.size() == 0) begin
                check("unexpected_areset_edge", int'(rr.areset), int'(prev_ar));
            end else begin
                cur = sbq.pop_front();
                check({cur.name, "_level"},   int'(rr.areset),  int'(cur.lvl));
                check({cur.name, "_cycle"},   cyc,              cur.at);
                check({cur.name, "_cause"},   int'(rr.cause),   int'(cur.cause));
                check({cur.name, "_running"}, int'(rr.running), int'(!cur.lvl));
            end
        end
        prev_ar = rr.areset;
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(logic lvl, int at, logic [4:0] c, string name);
        exp_t e;
        e.lvl = lvl; e.at = at; e.cause = c; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic drain(string name, int budget);
        int t = 0;
        while (sbq.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        check({name, "_drain"}, sbq.size(), 0);
        sbq.delete();
    endtask

    // Single-cycle software request; returns the cycle at which it was driven
    task automatic sw_pulse(output int n, input logic with_clr);
        n = cyc;
        rr.sw_req    = 1'b1;
        rr.cause_clr = with_clr;
        tick();
        rr.sw_req    = 1'b0;
        rr.cause_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, m, e, k, last, len, r, s, w, rel;
        rr.button     = 1'b0;
        rr.pll_locked = 1'b1;
        rr.sw_req     = 1'b0;
        rr.wdog_en    = 1'b0;
        rr.wdog_kick  = 1'b0;
        rr.cause_clr  = 1'b0;
        resetn        = 1'b0;

        // Power-on reset: 5 cycles low, then release with lock stable
        tick(5);
        check("por_areset",  int'(rr.areset),  1);
        check("por_running", int'(rr.running), 0);
        check("por_cause",   int'(rr.cause),   1);
        e = cyc;
        resetn  = 1'b1;
        prev_ar = rr.areset;
        mon_en  = 1'b1;
        push(1'b0, e + HOLD + LOCK, 5'b00001, "por_release");
        drain("por", 100);
        tick(5);

        // Button glitches shorter than the debounce window must be ignored
        for (int i = 0; i < 3; i++) begin
            len = (i == 0) ? 2 : int'($urandom_range(1, 6));
            rr.button = 1'b1;
            tick(len);
            rr.button = 1'b0;
            tick(20);
        end

        // Clean press with bouncing release: exactly one reset
        for (int i = 0; i < 2; i++) begin
            n = cyc;
            rr.button = 1'b1;
            r = n + SYNC + DEB + 1;
            push(1'b1, r,               5'b00010, "btn_rise");
            push(1'b0, r + HOLD + LOCK, 5'b00010, "btn_release");
            tick((i == 0) ? 20 : int'($urandom_range(12, 30)));
            repeat ($urandom_range(2, 5)) begin
                rr.button = 1'b0;
                tick($urandom_range(1, 5));
                rr.button = 1'b1;
                tick($urandom_range(1, 5));
            end
            rr.button = 1'b0;
            drain("btn", 200);
            tick(20);
        end

        // Watchdog: periodic kicks keep it quiet, then it expires after the last kick
        rr.wdog_en = 1'b1;
        k    = $urandom_range(20, 50);
        last = cyc;
        for (int i = 0; i < (200 / k) + 1; i++) begin
            tick(k - 1);
            last = cyc;
            rr.wdog_kick = 1'b1;
            tick();
            rr.wdog_kick = 1'b0;
        end
        r = last + 1 + WDOG_TO;
        push(1'b1, r,               5'b01000, "wdog_rise");
        push(1'b0, r + HOLD + LOCK, 5'b01000, "wdog_release");
        while (cyc < r + 2) tick();
        rr.wdog_en = 1'b0;
        drain("wdog", 200);
        tick(10);

        // PLL loss: release waits for both the hold and a fresh stable-lock window
        for (int i = 0; i < 3; i++) begin
            len = (i == 0) ? 30 : int'($urandom_range(3, 40));
            n = cyc;
            rr.pll_locked = 1'b0;
            r = n + SYNC + 1;
            push(1'b1, r, 5'b10000, "pll_rise");
            tick(len);
            rr.pll_locked = 1'b1;
            s   = n + len + SYNC;
            w   = r + HOLD;
            rel = ((w > s) ? w : s) + LOCK;
            push(1'b0, rel, 5'b10000, "pll_release");
            drain("pll", 200);
            tick(10);
        end

        // Request beats a simultaneous clear; a second request mid-hold restarts it;
        // a clear during reset is ignored
        sw_pulse(n, 1'b1);
        push(1'b1, n + 1, 5'b00100, "sw_rise");
        tick($urandom_range(2, 12));
        rr.cause_clr = 1'b1;
        tick();
        rr.cause_clr = 1'b0;
        sw_pulse(m, 1'b0);
        push(1'b0, m + 1 + HOLD + LOCK, 5'b00100, "sw_restart_release");
        drain("sw", 200);
        tick(5);

        // Clear in RUN empties the cause register
        rr.cause_clr = 1'b1;
        tick();
        rr.cause_clr = 1'b0;
        check("clr_cause",   int'(rr.cause),   0);
        check("clr_running", int'(rr.running), 1);
        tick(5);

        // resetn during WAIT_LOCK aborts to the reset values and restarts the hold
        sw_pulse(n, 1'b0);
        push(1'b1, n + 1, 5'b00100, "mid_rise");
        drain("mid_rise", 10);
        while (cyc < n + 1 + HOLD + int'($urandom_range(1, 6))) tick();
        resetn = 1'b0;
        tick();
        check("mid_rst_areset",  int'(rr.areset),  1);
        check("mid_rst_running", int'(rr.running), 0);
        check("mid_rst_cause",   int'(rr.cause),   1);
        tick($urandom_range(0, 2));
        e = cyc;
        resetn = 1'b1;
        push(1'b0, e + HOLD + LOCK, 5'b00001, "mid_rst_release");
        drain("mid_rst", 100);

        tick(10);
        check("final_areset",  int'(rr.areset),  0);
        check("final_running", int'(rr.running), 1);
        check("final_sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vcu118_reset_request.md
# vcu118_reset_request

Reset-request generator for the VCU118 shell, feeding the board reset sequencer. It gathers every system-reset source in the board clock domain and produces the single `areset` level that the sequencer consumes. `areset` is held high for a guaranteed minimum width and until the MMCM/PLL reports a stable lock. The sources are power-on, front-panel button, software request, watchdog timeout and PLL lock loss. A sticky cause register records why the last reset happened.

## Interface
- `HOLD_CYCLES`, 1024: minimum `areset` high time, in `clock` cycles.
- `LOCK_CYCLES`, 256: consecutive cycles `pll_locked` must be high before release.
- `DEBOUNCE_BITS`, 8: button must be stable for 2^DEBOUNCE_BITS cycles.
- `WDOG_BITS`, 24: watchdog counter width.

Ports:
- `clock`, in, 1: free-running board clock; sole clock.
- `resetn`, in, 1: synchronous, active-low reset.
- `button`, in, 1: asynchronous push button, active high.
- `pll_locked`, in, 1: asynchronous PLL/MMCM lock.
- `sw_req`, in, 1: single-cycle software reset request.
- `wdog_en`, in, 1: watchdog enable.
- `wdog_kick`, in, 1: watchdog restart pulse.
- `cause_clr`, in, 1: clears `cause`; honoured only in RUN.
- `areset`, out, 1: reset request to the sequencer, active high, registered.
- `cause`, out, 5: sticky cause. Bit 0 = POR, 1 = button, 2 = sw, 3 = watchdog, 4 = PLL loss.
- `running`, out, 1: high in RUN.

## Operation
- **Input synchronisers**
  - `button` and `pll_locked` each pass through a 2-flop synchroniser (`btn_s`, `lock_s`).
  - Synchroniser flops are not reset.
- **Button debounce**
  - A counter of DEBOUNCE_BITS+1 bits counts consecutive cycles of `btn_s` equal to its armed target level.
  - Armed-high (target 1): reaching 2^DEBOUNCE_BITS produces a one-cycle button request and switches to armed-low (target 0).
  - Armed-low: reaching 2^DEBOUNCE_BITS switches back to armed-high.
  - Any mismatch with the target zeroes the counter.
  - Result: exactly one request per press; release bounce is ignored.
- **Watchdog**
  - `wdog_cnt` (WDOG_BITS wide) is zero outside RUN, and in RUN whenever `wdog_en`=0 or `wdog_kick`=1.
  - Otherwise it increments each cycle.
  - A watchdog request fires when `wdog_cnt` is all-ones and `wdog_kick`=0.
- **PLL loss**: a request fires when `lock_s`=0 in RUN.
- **Request vector**: req[4:1] = {pll, wdog, sw_req, button}.
- **State machine**
  - HOLD:
    - `hold_cnt` increments each cycle.
    - When `hold_cnt`==HOLD_CYCLES-1, go to WAIT_LOCK and clear `lock_cnt`.
  - WAIT_LOCK:
    - `lock_cnt` increments while `lock_s`=1 and clears to 0 when `lock_s`=0.
    - When `lock_cnt`==LOCK_CYCLES-1 and `lock_s`=1, go to RUN.
  - RUN: any req bit set → HOLD with `hold_cnt`=0.
  - Any req bit set in HOLD or WAIT_LOCK → HOLD with `hold_cnt`=0 (restart).
  - The PLL-loss request is inactive outside RUN; WAIT_LOCK absorbs loss of lock.
- **Outputs**
  - `areset` = 1 in HOLD and WAIT_LOCK, 0 in RUN.
  - `running` = (state==RUN).
  - Both are registered from next-state.
- **Cause register**
  - RUN→HOLD: `cause` is loaded with {req, 1'b0}; the previous value is discarded.
  - In HOLD and WAIT_LOCK, new req bits are ORed in.
  - In RUN, `cause_clr` zeroes it.
  - `cause_clr` together with a request: the request wins.
- **resetn low**
  - state=HOLD, `hold_cnt`=0, `lock_cnt`=0, `wdog_cnt`=0.
  - Debounce counter 0, armed-high.
  - `areset`=1, `running`=0, `cause`=5'b00001.
  - `resetn` low mid-operation aborts everything to these values on the next edge.

## Timing
- Request sampled in RUN at edge N → `areset`=1 and `running`=0 after edge N+1.
- Release timing with `lock_s` high throughout: `areset` falls exactly HOLD_CYCLES+LOCK_CYCLES cycles after the entry into HOLD.
- Button latency: 2 synchroniser cycles + 2^DEBOUNCE_BITS debounce cycles, then 1 cycle to `areset`.
- Watchdog with `wdog_en` held and no kick: request fires 2^WDOG_BITS-1 cycles after RUN entry or after the last kick.
- PLL loss: `pll_locked` falling → `areset` high 3 cycles later (2 synchroniser + 1 register).
- Counters saturate implicitly through the state transitions; no wrap occurs in any state.

## Test plan
Parameters: HOLD_CYCLES=16, LOCK_CYCLES=8, DEBOUNCE_BITS=3, WDOG_BITS=6.
- **POR**: hold `resetn`=0 for 5 cycles, then release with `pll_locked`=1.
  - `areset`=1 for exactly 24 cycles, then 0; `running`=1; `cause`=00001.
- **Button**:
  - 2-cycle glitch on `button` → no reset.
  - Held 20 cycles → exactly one reset; `areset` rises 11 cycles after the rise; `cause`=00010.
  - Bouncing release → no second reset.
- **Watchdog**: in RUN, `wdog_en`=1.
  - Kick every 40 cycles for 200 cycles → no reset.
  - Stop kicking → `areset` rises 64 cycles after the last kick; `cause`=01000.
- **PLL loss**: drop `pll_locked` in RUN for 30 cycles.
  - `areset`=1 after 3 cycles; `cause`=10000.
  - Release occurs 8 lock cycles after HOLD ends and `lock_s` returns.
- **Simultaneous and restart**:
  - `sw_req` with `cause_clr` in the same cycle → `cause`=00100.
  - Second `sw_req` mid-HOLD → hold restarts; total high time is 24 cycles from the second request.
- **Reset mid-operation**: assert `resetn`=0 during WAIT_LOCK → next edge gives `areset`=1, `cause`=00001, with counters restarted.
